// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI preset controller: FSM state
// encoding, the Program Change status byte and the slot-empty flag position.
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEM_RD    = 3'd1,
        ST_TX_STATUS = 3'd2,
        ST_TX_PROG   = 3'd3,
        ST_MEM_WR    = 3'd4
    } state_e;

    localparam logic [7:0]  MIDI_PC        = 8'hC0;
    localparam int unsigned SLOT_EMPTY_BIT = 7;

    // Only buttons 1 and 2 map to preset slots; 0 and 3 are no-ops.
    function automatic logic is_slot_event(input logic [1:0] btn);
        return (btn == 2'd1) || (btn == 2'd2);
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Loadable down-counter guarding a memory handshake; expired is raised while
// enabled once the count has run down to zero.
module ack_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/preset_ctrl.sv
// MIDI preset controller: saves the current program to a memory slot or loads
// a slot and sends it out as a Program Change message over the UART.
module preset_ctrl
    import midi_pkg::*;
#(
    parameter logic [3:0]  MIDI_CH     = 4'd0,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_index,
    input  logic       save_mode,
    input  logic [6:0] midi_prog,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [1:0] active_slot,
    output logic       err
);

    // The timer runs ACK_TIMEOUT cycles: loaded one short because the
    // zero-count cycle itself is the last one mem_req stays high.
    localparam int unsigned    TW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMR_LOAD  = TW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]     STATUS_PC = MIDI_PC | {4'd0, MIDI_CH};

    state_e     state_q, state_d;
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_slot_q, pend_slot_d;
    logic       pend_save_q, pend_save_d;
    logic [6:0] pend_prog_q, pend_prog_d;
    logic [6:0] prog_q, prog_d;
    logic [1:0] active_slot_q, active_slot_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic [1:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic       ev_s;
    logic       start_s;
    logic [1:0] sel_slot_s;
    logic       sel_save_s;
    logic [6:0] sel_prog_s;
    logic       ack_s;
    logic       tmr_load_s;
    logic       tmr_en_s;
    logic       tmr_expired_s;

    assign ev_s       = is_slot_event(btn_index);
    assign start_s    = ev_s || pend_valid_q;
    assign sel_slot_s = ev_s ? btn_index : pend_slot_q;
    assign sel_save_s = ev_s ? save_mode : pend_save_q;
    assign sel_prog_s = ev_s ? midi_prog : pend_prog_q;
    assign ack_s      = mem_req_q && mem_ack;
    assign tmr_en_s   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

    ack_timer #(.WIDTH(TW)) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (TMR_LOAD),
        .en       (tmr_en_s),
        .expired  (tmr_expired_s)
    );

    // Next-state and registered-output computation for the controller FSM.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_slot_d   = pend_slot_q;
        pend_save_d   = pend_save_q;
        pend_prog_d   = pend_prog_q;
        prog_d        = prog_q;
        active_slot_d = active_slot_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        err_d         = 1'b0;
        tmr_load_s    = 1'b0;

        // While busy the single pending slot simply takes the newest event.
        if (ev_s && (state_q != ST_IDLE)) begin
            pend_valid_d = 1'b1;
            pend_slot_d  = btn_index;
            pend_save_d  = save_mode;
            pend_prog_d  = midi_prog;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d      = sel_save_s ? ST_MEM_WR : ST_MEM_RD;
                    pend_valid_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = sel_save_s;
                    mem_addr_d   = sel_slot_s;
                    mem_wdata_d  = {1'b0, sel_prog_s};
                    tmr_load_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (ack_s) begin
                    active_slot_d = mem_addr_q;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    state_d       = ST_IDLE;
                end else if (tmr_expired_s) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                // Ack is checked before expiry so a last-cycle ack still succeeds.
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    if (mem_rdata[SLOT_EMPTY_BIT]) begin
                        state_d = ST_IDLE;
                    end else begin
                        prog_d     = mem_rdata[6:0];
                        tx_valid_d = 1'b1;
                        tx_data_d  = STATUS_PC;
                        state_d    = ST_TX_STATUS;
                    end
                end else if (tmr_expired_s) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_TX_STATUS: begin
                if (tx_ready) begin
                    tx_data_d = {1'b0, prog_q};
                    state_d   = ST_TX_PROG;
                end else begin
                    state_d = ST_TX_STATUS;
                end
            end
            ST_TX_PROG: begin
                if (tx_ready) begin
                    tx_valid_d    = 1'b0;
                    active_slot_d = mem_addr_q;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_TX_PROG;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pend_valid_q  <= 1'b0;
            pend_slot_q   <= 2'd0;
            pend_save_q   <= 1'b0;
            pend_prog_q   <= 7'd0;
            prog_q        <= 7'd0;
            active_slot_q <= 2'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 2'd0;
            mem_wdata_q   <= 8'd0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'd0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_slot_q   <= pend_slot_d;
            pend_save_q   <= pend_save_d;
            pend_prog_q   <= pend_prog_d;
            prog_q        <= prog_d;
            active_slot_q <= active_slot_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign active_slot = active_slot_q;
    assign err         = err_q;

endmodule

// File: tb/tb_preset_ctrl.sv
// Self-checking bench for preset_ctrl: a memory responder, a UART sink monitor
// and a slot-level reference model predicting writes, MIDI bytes and active_slot.
module tb_preset_ctrl;

    localparam int unsigned ACK_TO  = 15;
    localparam logic [7:0]  PC_BYTE = 8'hC3;

    logic       clk;
    logic       rst;
    logic [1:0] btn_index;
    logic       save_mode;
    logic [6:0] midi_prog;
    logic       mem_req, mem_we, mem_ack;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       busy, err;
    logic [1:0] active_slot;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [4];
    logic [1:0]  ref_active;
    logic [7:0]  dev_mem [4];
    logic [10:0] op_log [$];
    logic [7:0]  tx_log [$];
    int          err_cnt = 0;
    int          req_cycles = 0;
    int          ack_lat;
    bit          ack_en;
    bit          tx_rand;

    preset_ctrl #(.MIDI_CH(4'd3), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
        .midi_prog(midi_prog), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .active_slot(active_slot), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: acks a held request after ack_lat cycles and logs the access.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        for (int i = 0; i < 4; i++) dev_mem[i] = 8'h80;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req && ack_en) begin
                if (lat_cnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        dev_mem[mem_addr] = mem_wdata;
                        op_log.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = dev_mem[mem_addr];
                        op_log.push_back({1'b0, mem_addr, 8'h00});
                    end
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Mid-cycle monitor: accepted UART bytes, err pulses, request cycles.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (err) err_cnt++;
        if (mem_req) req_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_rand) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_event(input logic [1:0] slot, input logic save, input logic [6:0] prog);
        btn_index = slot;
        save_mode = save;
        midi_prog = prog;
        tick();
        btn_index = 2'd0;
        save_mode = 1'($urandom_range(0, 1));
        midi_prog = 7'($urandom);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic check_tx(input string name, input int base, input logic [7:0] exp_tx [$]);
        int n = tx_log.size() - base;
        bit ok = (n == exp_tx.size());
        if (ok) for (int i = 0; i < n; i++) if (tx_log[base + i] !== exp_tx[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s tx: got %0d bytes last %h, required %0d bytes last %h", name, n,
                     (n > 0) ? tx_log[tx_log.size() - 1] : 8'h00, exp_tx.size(),
                     (exp_tx.size() > 0) ? exp_tx[exp_tx.size() - 1] : 8'h00);
        end
    endtask

    // One complete operation predicted from the slot-level model.
    task automatic do_op(input logic [1:0] slot, input logic save, input logic [6:0] prog, input string name);
        int ob = op_log.size();
        int tb0 = tx_log.size();
        logic [7:0]  exp_tx [$];
        logic [10:0] exp_op;
        logic [1:0]  exp_active = ref_active;
        logic [7:0]  b;
        if (save) begin
            exp_op = {1'b1, slot, 1'b0, prog};
            ref_mem[slot] = {1'b0, prog};
            exp_active = slot;
        end else begin
            exp_op = {1'b0, slot, 8'h00};
            b = ref_mem[slot];
            if (!b[7]) begin
                exp_tx.push_back(PC_BYTE);
                exp_tx.push_back({1'b0, b[6:0]});
                exp_active = slot;
            end
        end
        send_event(slot, save, prog);
        wait_idle(name, 300);
        checks++;
        if (op_log.size() != ob + 1) begin
            errors++;
            $display("FAIL %s memops: got %0d accesses, required 1", name, op_log.size() - ob);
        end else if (op_log[ob] !== exp_op) begin
            errors++;
            $display("FAIL %s memop: got %h, required %h", name, op_log[ob], exp_op);
        end
        check_tx(name, tb0, exp_tx);
        checks++;
        if (active_slot !== exp_active) begin
            errors++;
            $display("FAIL %s active_slot: got %0d, required %0d", name, active_slot, exp_active);
        end
        ref_active = exp_active;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        rst = 1'b0;
        repeat (3) tick();
        got = {mem_req, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, busy, active_slot, err};
        checks++;
        if (got !== 27'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h, required 0", got);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset release: busy=%b mem_req=%b, required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_empty_slot();
        tx_ready = 1'b1;
        ack_lat = 1;
        do_op(2'd1, 1'b0, 7'd9, "empty_slot");
    endtask

    task automatic test_save();
        ack_lat = 2;
        do_op(2'd1, 1'b1, 7'd42, "save42");
    endtask

    task automatic test_load();
        ack_lat = 0;
        do_op(2'd2, 1'b1, 7'd5, "save5");
        ack_lat = 3;
        do_op(2'd2, 1'b0, 7'd0, "load5");
    endtask

    task automatic test_no_event();
        int ob;
        for (int k = 0; k < 2; k++) begin
            ob = op_log.size();
            send_event((k == 0) ? 2'd3 : 2'd0, 1'b1, 7'd77);
            repeat (3) tick();
            checks++;
            if (busy !== 1'b0 || op_log.size() != ob) begin
                errors++;
                $display("FAIL no_event btn%0d: busy=%b accesses=%0d, required 0 0", (k == 0) ? 3 : 0, busy, op_log.size() - ob);
            end
        end
    endtask

    task automatic test_backpressure();
        int tb0 = tx_log.size();
        int n = 0;
        logic [7:0] exp_tx [$];
        exp_tx.push_back(PC_BYTE);
        exp_tx.push_back({1'b0, ref_mem[2][6:0]});
        tx_ready = 1'b0;
        ack_lat = 1;
        send_event(2'd2, 1'b0, 7'd1);
        while (!tx_valid && n < 50) begin tick(); n++; end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== PC_BYTE) begin
            errors++;
            $display("FAIL bp first: valid=%b data=%h, required 1 %h", tx_valid, tx_data, PC_BYTE);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== PC_BYTE) begin
                errors++;
                $display("FAIL bp hold%0d: valid=%b data=%h, required 1 %h", c, tx_valid, tx_data, PC_BYTE);
            end
        end
        tx_ready = 1'b1;
        wait_idle("bp", 50);
        check_tx("bp", tb0, exp_tx);
        ref_active = 2'd2;
        checks++;
        if (active_slot !== 2'd2) begin
            errors++;
            $display("FAIL bp active_slot: got %0d, required 2", active_slot);
        end
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        int r0 = req_cycles;
        int ob = op_log.size();
        ack_en = 0;
        send_event(2'd1, 1'b0, 7'd3);
        wait_idle("timeout", ACK_TO + 20);
        tick();
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout err pulses: got %0d, required 1", err_cnt - e0);
        end
        checks++;
        if (req_cycles - r0 < ACK_TO || req_cycles - r0 > ACK_TO + 2) begin
            errors++;
            $display("FAIL timeout req cycles: got %0d, required %0d..%0d", req_cycles - r0, ACK_TO, ACK_TO + 2);
        end
        checks++;
        if (mem_req !== 1'b0 || err !== 1'b0 || active_slot !== ref_active || op_log.size() != ob) begin
            errors++;
            $display("FAIL timeout final: req=%b err=%b slot=%0d, required 0 0 %0d", mem_req, err, active_slot, ref_active);
        end
        ack_en = 1;
    endtask

    task automatic test_overwrite();
        int ob, tb0;
        logic [7:0] exp_tx [$];
        ack_lat = 0;
        tx_ready = 1'b1;
        do_op(2'd1, 1'b1, 7'h33, "ow_pre1");
        do_op(2'd2, 1'b1, 7'h4C, "ow_pre2");
        exp_tx = '{PC_BYTE, 8'h33, PC_BYTE, 8'h4C};
        ob = op_log.size();
        tb0 = tx_log.size();
        ack_lat = 4;
        send_event(2'd1, 1'b0, 7'd0);
        send_event(2'd1, 1'b1, 7'h11);
        send_event(2'd2, 1'b0, 7'd0);
        wait_idle("ow_first", 100);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ow gap: busy=%b one cycle after idle, required 1", busy);
        end
        wait_idle("ow_second", 100);
        checks++;
        if (op_log.size() != ob + 2 || op_log[ob] !== 11'h100 || op_log[ob + 1] !== 11'h200) begin
            errors++;
            $display("FAIL ow memops: got %0d accesses, required reads of slot 1 then 2", op_log.size() - ob);
        end
        check_tx("ow", tb0, exp_tx);
        ref_active = 2'd2;
        checks++;
        if (active_slot !== 2'd2) begin
            errors++;
            $display("FAIL ow active_slot: got %0d, required 2", active_slot);
        end
    endtask

    task automatic test_random();
        logic [1:0] s;
        tx_rand = 1;
        for (int k = 0; k < 24; k++) begin
            s = 2'($urandom_range(0, 3));
            ack_lat = $urandom_range(0, 3);
            if (s == 2'd1 || s == 2'd2) do_op(s, 1'($urandom_range(0, 1)), 7'($urandom), "rand");
            else test_no_event();
        end
        tx_rand = 0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ack_lat = 1;
        tx_ready = 1'b0;
        do_op(2'd2, 1'b1, 7'h61, "rm_pre");
        send_event(2'd2, 1'b0, 7'd0);
        while (!tx_valid && n < 50) begin tick(); n++; end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h61) begin
            errors++;
            $display("FAIL rm prog byte: valid=%b data=%h, required 1 61", tx_valid, tx_data);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || active_slot !== 2'd0) begin
            errors++;
            $display("FAIL rm reset: valid=%b busy=%b req=%b slot=%0d, required 0 0 0 0", tx_valid, busy, mem_req, active_slot);
        end
        tick();
        rst = 1'b1;
        ref_active = 2'd0;
        tx_ready = 1'b1;
        do_op(2'd1, 1'b0, 7'd0, "rm_after");
    endtask

    initial begin
        rst = 1'b0;
        btn_index = 2'd0;
        save_mode = 1'b0;
        midi_prog = 7'd0;
        tx_ready = 1'b0;
        tx_rand = 0;
        ack_en = 1;
        ack_lat = 1;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h80;
        ref_active = 2'd0;
        test_reset();
        test_empty_slot();
        test_save();
        test_load();
        test_no_event();
        test_backpressure();
        test_timeout();
        test_overwrite();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
